// File: rtl/ex_stage_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module  : ex_stage_muldiv
// Brief   : Execute stage with forwarding, ALU/branch path, iterative RV32M
//           multiply/divide unit and the EX/MEM output register.
// Revision: 1.0 - initial release
//============================================================================
module ex_stage_muldiv #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_e,
    input  logic               flush_e,
    input  logic [XLEN-1:0]    rd1_e,
    input  logic [XLEN-1:0]    rd2_e,
    input  logic [XLEN-1:0]    imm_e,
    input  logic [XLEN-1:0]    pc_e,
    input  logic [1:0]         fwd_a,
    input  logic [1:0]         fwd_b,
    input  logic [XLEN-1:0]    wb_result_w,
    input  logic               alu_src_e,
    input  logic [ALUOP_W-1:0] alu_ctrl_e,
    input  logic [2:0]         funct3_e,
    input  logic               branch_e,
    input  logic               muldiv_e,
    input  logic [4:0]         rd_e,
    input  logic               reg_write_e,
    input  logic               mem_write_e,
    output logic               stall_o,
    output logic               pcsrc_e,
    output logic [XLEN-1:0]    branch_tgt_e,
    output logic               valid_m,
    output logic [XLEN-1:0]    alu_result_m,
    output logic [XLEN-1:0]    write_data_m,
    output logic [4:0]         rd_m,
    output logic               reg_write_m,
    output logic               mem_write_m
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  C_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    // Team ALU encoding
    localparam logic [ALUOP_W-1:0] C_ALU_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] C_ALU_SUB  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] C_ALU_SLL  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] C_ALU_SLT  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] C_ALU_SLTU = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] C_ALU_XOR  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] C_ALU_SRL  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] C_ALU_SRA  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] C_ALU_OR   = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] C_ALU_AND  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] C_ALU_PASSB = ALUOP_W'(10);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [XLEN-1:0]  w_op_a, w_b_reg, w_op_b, w_alu;
    logic [CNT_W-1:0] w_shamt;
    logic             w_cond;

    always_comb begin
        case (fwd_a)
            2'b01:   w_op_a = alu_result_m;
            2'b10:   w_op_a = wb_result_w;
            default: w_op_a = rd1_e;
        endcase
        case (fwd_b)
            2'b01:   w_b_reg = alu_result_m;
            2'b10:   w_b_reg = wb_result_w;
            default: w_b_reg = rd2_e;
        endcase
    end

    assign w_op_b  = alu_src_e ? imm_e : w_b_reg;
    assign w_shamt = w_op_b[CNT_W-1:0];

    always_comb begin
        w_alu = '0;
        case (alu_ctrl_e)
            C_ALU_ADD:   w_alu = w_op_a + w_op_b;
            C_ALU_SUB:   w_alu = w_op_a - w_op_b;
            C_ALU_SLL:   w_alu = w_op_a << w_shamt;
            C_ALU_SLT:   w_alu = {{(XLEN-1){1'b0}}, $signed(w_op_a) < $signed(w_op_b)};
            C_ALU_SLTU:  w_alu = {{(XLEN-1){1'b0}}, w_op_a < w_op_b};
            C_ALU_XOR:   w_alu = w_op_a ^ w_op_b;
            C_ALU_SRL:   w_alu = w_op_a >> w_shamt;
            C_ALU_SRA:   w_alu = $signed(w_op_a) >>> w_shamt;
            C_ALU_OR:    w_alu = w_op_a | w_op_b;
            C_ALU_AND:   w_alu = w_op_a & w_op_b;
            C_ALU_PASSB: w_alu = w_op_b;
            default:     w_alu = '0;
        endcase
    end

    // Branches compare against the register operand, never the immediate
    always_comb begin
        w_cond = 1'b0;
        case (funct3_e)
            3'b000:  w_cond = (w_op_a == w_b_reg);
            3'b001:  w_cond = (w_op_a != w_b_reg);
            3'b100:  w_cond = ($signed(w_op_a) <  $signed(w_b_reg));
            3'b101:  w_cond = ($signed(w_op_a) >= $signed(w_b_reg));
            3'b110:  w_cond = (w_op_a <  w_b_reg);
            3'b111:  w_cond = (w_op_a >= w_b_reg);
            default: w_cond = 1'b0;
        endcase
    end

    assign pcsrc_e      = valid_e & branch_e & ~flush_e & w_cond;
    assign branch_tgt_e = pc_e + imm_e;

    // Mul/div issue decode
    logic            w_start, w_is_div, w_sa, w_sb, w_neg_a, w_neg_b;
    logic            w_div_zero, w_div_ovf;
    logic [XLEN-1:0] w_mag_a, w_mag_b, w_special_val;

    assign w_start    = valid_e & muldiv_e & ~flush_e;
    assign w_is_div   = funct3_e[2];
    assign w_sa       = w_is_div ? ~funct3_e[0] : (funct3_e[1] ^ funct3_e[0]);
    assign w_sb       = w_is_div ? ~funct3_e[0] : (funct3_e[1:0] == 2'b01);
    assign w_neg_a    = w_sa & w_op_a[XLEN-1];
    assign w_neg_b    = w_sb & w_b_reg[XLEN-1];
    assign w_mag_a    = w_neg_a ? -w_op_a  : w_op_a;
    assign w_mag_b    = w_neg_b ? -w_b_reg : w_b_reg;
    assign w_div_zero = (w_b_reg == '0);
    assign w_div_ovf  = ~funct3_e[0] & (w_op_a == C_INT_MIN) & (&w_b_reg);

    always_comb begin
        if (w_div_zero) w_special_val = funct3_e[1] ? w_op_a : '1;
        else            w_special_val = funct3_e[1] ? '0 : C_INT_MIN;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (!w_is_div)                    w_state_nxt = S_MUL;
                    else if (w_div_zero || w_div_ovf) w_state_nxt = S_DONE;
                    else                              w_state_nxt = S_DIV;
                end
            end
            S_MUL, S_DIV: if (r_cnt == C_CNT_LAST) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush_e) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    assign stall_o = ~flush_e & ((r_state == S_IDLE & w_start) |
                                 (r_state == S_MUL) | (r_state == S_DIV));

    // Iteration datapath: {r_hi, r_lo} is the product, or remainder/quotient
    logic [XLEN-1:0]  r_hi, r_lo, r_mcand, r_special_val;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_f3;
    logic [4:0]       r_rd;
    logic             r_neg_res, r_neg_rem, r_special, r_reg_write;
    logic [XLEN:0]    w_mul_sum, w_rem_sh, w_diff;

    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_rem_sh  = {r_hi, r_lo[XLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_mcand};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi          <= '0;
            r_lo          <= '0;
            r_mcand       <= '0;
            r_special_val <= '0;
            r_cnt         <= '0;
            r_f3          <= '0;
            r_rd          <= '0;
            r_neg_res     <= 1'b0;
            r_neg_rem     <= 1'b0;
            r_special     <= 1'b0;
            r_reg_write   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_start) begin
                r_hi          <= '0;
                r_lo          <= w_mag_a;
                r_mcand       <= w_mag_b;
                r_special_val <= w_special_val;
                r_cnt         <= '0;
                r_f3          <= funct3_e;
                r_rd          <= rd_e;
                r_neg_res     <= w_neg_a ^ w_neg_b;
                r_neg_rem     <= w_neg_a;
                r_special     <= w_is_div & (w_div_zero | w_div_ovf);
                r_reg_write   <= reg_write_e;
            end
        end else if (r_state == S_MUL) begin
            r_hi  <= w_mul_sum[XLEN:1];
            r_lo  <= {w_mul_sum[0], r_lo[XLEN-1:1]};
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (r_state == S_DIV) begin
            r_hi  <= w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
            r_lo  <= {r_lo[XLEN-2:0], ~w_diff[XLEN]};
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    logic [2*XLEN-1:0] w_prod, w_prod_fix;
    logic [XLEN-1:0]   w_md_result;

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_neg_res ? -w_prod : w_prod;

    always_comb begin
        w_md_result = '0;
        case (r_f3)
            3'b000:               w_md_result = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_md_result = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:       w_md_result = r_neg_res ? -r_lo : r_lo;
            default:              w_md_result = r_neg_rem ? -r_hi : r_hi;
        endcase
        if (r_special) w_md_result = r_special_val;
    end

    // EX/MEM register; busy or flushed cycles load a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_m      <= 1'b0;
            alu_result_m <= '0;
            write_data_m <= '0;
            rd_m         <= '0;
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
        end else if (flush_e) begin
            valid_m     <= 1'b0;
            reg_write_m <= 1'b0;
            mem_write_m <= 1'b0;
        end else if (r_state == S_DONE) begin
            valid_m      <= 1'b1;
            alu_result_m <= w_md_result;
            write_data_m <= w_b_reg;
            rd_m         <= r_rd;
            reg_write_m  <= r_reg_write;
            mem_write_m  <= 1'b0;
        end else if (r_state == S_IDLE && !w_start) begin
            valid_m      <= valid_e;
            alu_result_m <= w_alu;
            write_data_m <= w_b_reg;
            rd_m         <= rd_e;
            reg_write_m  <= valid_e & reg_write_e;
            mem_write_m  <= valid_e & mem_write_e;
        end else begin
            valid_m     <= 1'b0;
            reg_write_m <= 1'b0;
            mem_write_m <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module  : tb_ex_stage_muldiv
// Brief   : Directed and randomized bench for ex_stage_muldiv (XLEN=32).
// Revision: 1.0 - initial release
//============================================================================
module tb_ex_stage_muldiv;

    logic        clk = 1'b0;
    logic        rst_n, valid_e, flush_e, alu_src_e, branch_e, muldiv_e;
    logic        reg_write_e, mem_write_e;
    logic [31:0] rd1_e, rd2_e, imm_e, pc_e, wb_result_w;
    logic [1:0]  fwd_a, fwd_b;
    logic [4:0]  alu_ctrl_e, rd_e;
    logic [2:0]  funct3_e;
    logic        stall_o, pcsrc_e, valid_m, reg_write_m, mem_write_m;
    logic [31:0] branch_tgt_e, alu_result_m, write_data_m;
    logic [4:0]  rd_m;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_m;
    bit          m_known;

    always #5 clk = ~clk;

    ex_stage_muldiv #(.XLEN(32), .ALUOP_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .valid_e(valid_e), .flush_e(flush_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_result_w(wb_result_w),
        .alu_src_e(alu_src_e), .alu_ctrl_e(alu_ctrl_e), .funct3_e(funct3_e),
        .branch_e(branch_e), .muldiv_e(muldiv_e), .rd_e(rd_e),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
        .stall_o(stall_o), .pcsrc_e(pcsrc_e), .branch_tgt_e(branch_tgt_e),
        .valid_m(valid_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        valid_e = 0; flush_e = 0; alu_src_e = 0; branch_e = 0; muldiv_e = 0;
        reg_write_e = 0; mem_write_e = 0; rd1_e = 0; rd2_e = 0; imm_e = 0;
        pc_e = 0; wb_result_w = 0; fwd_a = 0; fwd_b = 0; alu_ctrl_e = 0;
        rd_e = 0; funct3_e = 0;
    endtask

    // ALU ops 0..10: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND PASSB
    function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  return (a < b) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> b[4:0];
            5'd7:  return 32'(sa >>> b[4:0]);
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit br_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        case (f)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return sa < sb;
            3'b101: return sa >= sb;
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] md_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        bit ovf;
        sa = a; sb = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b};             return p[31:0];  end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b};       return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b};             return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] fwd_val(input logic [1:0] sel, input logic [31:0] r, input logic [31:0] wb);
        if (sel == 2'b01) return exp_m;
        if (sel == 2'b10) return wb;
        return r;
    endfunction

    task automatic do_alu(input string tag, input logic [4:0] op, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] im, input logic src,
                          input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] wb);
        logic [31:0] a, breg, exp;
        logic [4:0]  rdv;
        rdv = 5'($urandom_range(1, 31));
        valid_e = 1; muldiv_e = 0; branch_e = 0; flush_e = 0;
        alu_ctrl_e = op; rd1_e = r1; rd2_e = r2; imm_e = im; alu_src_e = src;
        fwd_a = fa; fwd_b = fb; wb_result_w = wb; rd_e = rdv; reg_write_e = 1; mem_write_e = 0;
        a = fwd_val(fa, r1, wb);
        breg = fwd_val(fb, r2, wb);
        exp = alu_ref(op, a, src ? im : breg);
        #1;
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
        tick();
        chk({tag, "_result"}, alu_result_m, exp);
        chk({tag, "_valid"}, 32'(valid_m), 32'd1);
        chk({tag, "_wdata"}, write_data_m, breg);
        chk({tag, "_rd"}, 32'(rd_m), 32'(rdv));
        exp_m = exp;
        m_known = 1;
    endtask

    task automatic do_md(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        logic [4:0]  rdv;
        int n, exp_n;
        rdv = 5'($urandom_range(1, 31));
        valid_e = 1; muldiv_e = 1; branch_e = 0; flush_e = 0; funct3_e = f;
        rd1_e = a; rd2_e = b; fwd_a = 0; fwd_b = 0; alu_src_e = 0;
        alu_ctrl_e = 0; rd_e = rdv; reg_write_e = 1; mem_write_e = 0;
        exp = md_ref(f, a, b);
        exp_n = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
        #1;
        n = 0;
        while (stall_o && n < 40) begin
            n++;
            tick();
        end
        chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_n));
        chk({tag, "_busy_bubble"}, 32'(valid_m), 32'd0);
        tick();
        chk({tag, "_result"}, alu_result_m, exp);
        chk({tag, "_valid"}, 32'(valid_m), 32'd1);
        chk({tag, "_rd"}, 32'(rd_m), 32'(rdv));
        chk({tag, "_regwr"}, 32'(reg_write_m), 32'd1);
        set_idle();
        exp_m = exp;
        m_known = 1;
    endtask

    task automatic do_branch(input string tag, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] pc, input logic [31:0] im);
        valid_e = 1; muldiv_e = 0; branch_e = 1; flush_e = 0; funct3_e = f;
        rd1_e = a; rd2_e = b; pc_e = pc; imm_e = im; fwd_a = 0; fwd_b = 0; alu_src_e = 0;
        #1;
        chk({tag, "_pcsrc"}, 32'(pcsrc_e), 32'(br_ref(f, a, b)));
        chk({tag, "_tgt"}, branch_tgt_e, pc + im);
        flush_e = 1;
        #1;
        chk({tag, "_pcsrc_flushed"}, 32'(pcsrc_e), 32'd0);
        tick();
        chk({tag, "_flush_bubble"}, 32'(valid_m), 32'd0);
        set_idle();
        m_known = 0;
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        set_idle();
        rst_n = 0;
        m_known = 0;
        exp_m = 0;
        tick();
        tick();
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_valid_m", 32'(valid_m), 32'd0);
        chk("rst_result_m", alu_result_m, 32'd0);
        chk("rst_regwr_m", 32'(reg_write_m), 32'd0);
        chk("rst_memwr_m", 32'(mem_write_m), 32'd0);
        rst_n = 1;
        m_known = 1;

        do_alu("add_imm", 5'd0, 32'd5, 32'd0, 32'd7, 1'b1, 2'b00, 2'b00, 32'd0);
        chk("add_imm_exact", alu_result_m, 32'd12);
        do_alu("seed_fwd", 5'd0, 32'h10, 32'd0, 32'd0, 1'b1, 2'b00, 2'b00, 32'd0);
        do_alu("sub_fwd_m", 5'd1, 32'd0, 32'd0, 32'd1, 1'b1, 2'b01, 2'b00, 32'd0);
        chk("sub_fwd_m_exact", alu_result_m, 32'h0F);
        do_alu("add_fwd_wb", 5'd0, 32'd3, 32'd0, 32'd0, 1'b0, 2'b00, 2'b10, 32'h100);
        do_alu("sra_fwd11", 5'd7, 32'h8000_0010, 32'd4, 32'd0, 1'b0, 2'b11, 2'b11, 32'd0);

        do_md("mul", 3'd0, 32'hFFFF_FFFF, 32'd2);
        chk("mul_exact", alu_result_m, 32'hFFFF_FFFE);
        do_md("mulh", 3'd1, 32'hFFFF_FFFF, 32'd2);
        chk("mulh_exact", alu_result_m, 32'hFFFF_FFFF);
        do_md("mulhu", 3'd3, 32'hFFFF_FFFF, 32'd2);
        chk("mulhu_exact", alu_result_m, 32'h1);
        do_md("div", 3'd4, 32'hFFFF_FFF9, 32'd2);
        chk("div_exact", alu_result_m, 32'hFFFF_FFFD);
        do_md("rem", 3'd6, 32'hFFFF_FFF9, 32'd2);
        chk("rem_exact", alu_result_m, 32'hFFFF_FFFF);
        do_md("divu_zero", 3'd5, 32'd7, 32'd0);
        do_md("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("rem_ovf_exact", alu_result_m, 32'd0);
        do_md("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        do_md("rem_zero", 3'd6, 32'hFFFF_FFF9, 32'd0);

        do_branch("blt", 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h1000, 32'h40);
        chk("blt_taken", 32'(br_ref(3'b100, 32'hFFFF_FFFF, 32'd1)), 32'd1);
        do_branch("bltu", 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h1000, 32'h40);

        // Flush during a divide
        valid_e = 1; muldiv_e = 1; funct3_e = 3'd4; rd1_e = 32'd100; rd2_e = 32'd3;
        reg_write_e = 1; rd_e = 5'd9;
        repeat (11) tick();
        chk("flush_pre_stall", 32'(stall_o), 32'd1);
        flush_e = 1;
        #1;
        chk("flush_stall", 32'(stall_o), 32'd0);
        tick();
        set_idle();
        chk("flush_no_valid", 32'(valid_m), 32'd0);
        chk("flush_no_regwr", 32'(reg_write_m), 32'd0);
        repeat (40) begin
            tick();
            if (valid_m !== 1'b0) chk("flush_no_commit", 32'(valid_m), 32'd0);
        end
        chk("flush_idle_stall", 32'(stall_o), 32'd0);
        do_md("after_flush", 3'd4, 32'd100, 32'd3);

        // Asynchronous reset mid-multiply
        valid_e = 1; muldiv_e = 1; funct3_e = 3'd0; rd1_e = 32'd12345; rd2_e = 32'd678;
        reg_write_e = 1; rd_e = 5'd7;
        repeat (6) tick();
        rst_n = 0;
        set_idle();
        #1;
        chk("arst_stall", 32'(stall_o), 32'd0);
        chk("arst_valid", 32'(valid_m), 32'd0);
        chk("arst_result", alu_result_m, 32'd0);
        chk("arst_wdata", write_data_m, 32'd0);
        chk("arst_rd", 32'(rd_m), 32'd0);
        chk("arst_regwr", 32'(reg_write_m), 32'd0);
        tick();
        rst_n = 1;
        exp_m = 0;
        m_known = 1;
        tick();
        m_known = 0;
        do_md("after_rst", 3'd0, 32'd12345, 32'd678);

        // Randomized ALU, branch and mul/div traffic
        for (int i = 0; i < 40; i++) begin
            logic [1:0] fa, fb;
            fa = 2'($urandom_range(0, 3));
            fb = 2'($urandom_range(0, 3));
            if (!m_known && fa == 2'b01) fa = 2'b00;
            if (!m_known && fb == 2'b01) fb = 2'b00;
            do_alu("rnd_alu", 5'($urandom_range(0, 10)), $urandom, $urandom,
                   32'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), fa, fb, $urandom);
        end
        for (int i = 0; i < 12; i++) begin
            logic [2:0] f;
            f = 3'($urandom_range(0, 7));
            if (f[2:1] == 2'b01) f = 3'b000;
            do_branch("rnd_br", f, rnd_opnd(), rnd_opnd(), $urandom, $urandom);
        end
        for (int i = 0; i < 24; i++) begin
            do_md("rnd_md", 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
